// File: rtl/mrv1_pkg.sv
// Shared definitions for the mrv1 warp-control path: op encoding and default table widths.
package mrv1_pkg;

  typedef enum logic [1:0] {
    OpWspawn = 2'd0,
    OpTmc    = 2'd1,
    OpBar    = 2'd2,
    OpBarQry = 2'd3
  } xrv_tw_ctl_op_e;

  // Widths for the default core configuration (8 warps, 8 barriers).
  localparam int unsigned WIDW = $clog2(8);
  localparam int unsigned BIDW = $clog2(8);

  // Index width that stays legal for single-entry configurations.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mrv1_barrier_table.sv
// Barrier table: per-barrier arrival count, latched size and waiting-warp mask.
// Decision for the arriving warp is combinational; the entry updates on the same edge.
module mrv1_barrier_table
  import mrv1_pkg::*;
#(
  parameter int unsigned NUM_WARPS_P    = 8,
  parameter int unsigned NUM_BARRIERS_P = 8,
  localparam int unsigned WidW = clog2_min1(NUM_WARPS_P),
  localparam int unsigned BidW = clog2_min1(NUM_BARRIERS_P),
  localparam int unsigned CntW = $clog2(NUM_WARPS_P + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   arrive_i,
  input  logic [BidW-1:0]        bid_i,
  input  logic [WidW-1:0]        wid_i,
  input  logic [31:0]            size_i,
  output logic                   release_o,
  output logic [NUM_WARPS_P-1:0] release_wmask_o,
  output logic                   stall_o,
  output logic                   dup_o,
  output logic [CntW-1:0]        count_o
);

  logic [CntW-1:0]        cnt_q   [NUM_BARRIERS_P];
  logic [CntW-1:0]        cnt_d   [NUM_BARRIERS_P];
  logic [CntW-1:0]        szm1_q  [NUM_BARRIERS_P];
  logic [CntW-1:0]        szm1_d  [NUM_BARRIERS_P];
  logic [NUM_WARPS_P-1:0] wait_q  [NUM_BARRIERS_P];
  logic [NUM_WARPS_P-1:0] wait_d  [NUM_BARRIERS_P];

  logic [31:0]            size_clamp;
  logic [CntW-1:0]        szm1_new;
  logic [CntW-1:0]        szm1_eff;
  logic [NUM_WARPS_P-1:0] wid_bit;

  always_comb begin
    cnt_d  = cnt_q;
    szm1_d = szm1_q;
    wait_d = wait_q;

    size_clamp = (size_i == 32'd0) ? 32'd1 : size_i;
    if (size_clamp > 32'(NUM_WARPS_P)) size_clamp = 32'(NUM_WARPS_P);
    szm1_new = CntW'(size_clamp - 32'd1);
    // The size is only latched by the first arrival; later src1 values are ignored.
    szm1_eff = (cnt_q[bid_i] == '0) ? szm1_new : szm1_q[bid_i];
    wid_bit  = NUM_WARPS_P'(1) << wid_i;

    count_o         = cnt_q[bid_i];
    dup_o           = arrive_i & wait_q[bid_i][wid_i];
    release_o       = arrive_i & ~dup_o & (cnt_q[bid_i] == szm1_eff);
    stall_o         = arrive_i & ~dup_o & ~release_o;
    release_wmask_o = release_o ? (wait_q[bid_i] | wid_bit) : '0;

    if (release_o) begin
      cnt_d[bid_i]  = '0;
      szm1_d[bid_i] = '0;
      wait_d[bid_i] = '0;
    end else if (stall_o) begin
      cnt_d[bid_i]  = cnt_q[bid_i] + CntW'(1);
      szm1_d[bid_i] = szm1_eff;
      wait_d[bid_i] = wait_q[bid_i] | wid_bit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_BARRIERS_P); i++) begin
        cnt_q[i]  <= '0;
        szm1_q[i] <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      szm1_q <= szm1_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/mrv1_tw_ctl_unit.sv
// Warp-control execution unit: executes WSPAWN/TMC/BAR/BAR_QRY and drives scheduler side-band.
// Every result and side-band pulse is registered and appears exactly one cycle after accept.
module mrv1_tw_ctl_unit
  import mrv1_pkg::*;
#(
  parameter int unsigned NUM_WARPS_P    = 8,
  parameter int unsigned NUM_THREADS_P  = 4,
  parameter int unsigned NUM_BARRIERS_P = 8,
  parameter int unsigned ITAG_WIDTH_P   = 1,
  localparam int unsigned WidW = clog2_min1(NUM_WARPS_P),
  localparam int unsigned BidW = clog2_min1(NUM_BARRIERS_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     tw_ctl_req_i,
  output logic                     tw_ctl_rdy_o,
  input  xrv_tw_ctl_op_e           tw_ctl_opc_i,
  input  logic [WidW-1:0]          tw_ctl_wid_i,
  input  logic [31:0]              tw_ctl_src0_i,
  input  logic [31:0]              tw_ctl_src1_i,
  input  logic [ITAG_WIDTH_P-1:0]  tw_ctl_itag_i,
  output logic                     tw_ctl_done_o,
  output logic [31:0]              tw_ctl_wb_data_o,
  output logic [ITAG_WIDTH_P-1:0]  tw_ctl_itag_o,
  output logic                     tw_ctl_wspawn_vld_o,
  output logic [NUM_WARPS_P-1:0]   tw_ctl_wspawn_wmask_o,
  output logic [31:0]              tw_ctl_wspawn_pc_o,
  output logic                     tw_ctl_tmc_vld_o,
  output logic [WidW-1:0]          tw_ctl_tmc_wid_o,
  output logic [NUM_THREADS_P-1:0] tw_ctl_tmc_tmask_o,
  output logic                     tw_ctl_stall_vld_o,
  output logic [WidW-1:0]          tw_ctl_stall_wid_o,
  output logic                     tw_ctl_release_vld_o,
  output logic [NUM_WARPS_P-1:0]   tw_ctl_release_wmask_o,
  output logic                     tw_ctl_err_o
);

  localparam int unsigned CntW = $clog2(NUM_WARPS_P + 1);

  logic                     rdy_q, done_q, done_d, err_q, err_d;
  logic [31:0]              wb_q, wb_d, pc_q, pc_d;
  logic [ITAG_WIDTH_P-1:0]  itag_q, itag_d;
  logic                     spawn_q, spawn_d, tmc_q, tmc_d, stall_q, stall_d, rel_q, rel_d;
  logic [NUM_WARPS_P-1:0]   smask_q, smask_d, rmask_q, rmask_d;
  logic [WidW-1:0]          twid_q, twid_d, swid_q, swid_d;
  logic [NUM_THREADS_P-1:0] tmask_q, tmask_d;

  logic                     accept, bad_bid, arrive;
  logic [31:0]              spawn_n;
  logic                     tbl_release, tbl_stall, tbl_dup;
  logic [NUM_WARPS_P-1:0]   tbl_rmask;
  logic [CntW-1:0]          tbl_count;

  assign accept  = tw_ctl_req_i & rdy_q;
  assign bad_bid = tw_ctl_src0_i >= 32'(NUM_BARRIERS_P);
  assign arrive  = accept & (tw_ctl_opc_i == OpBar) & ~bad_bid;

  mrv1_barrier_table #(
    .NUM_WARPS_P    (NUM_WARPS_P),
    .NUM_BARRIERS_P (NUM_BARRIERS_P)
  ) u_barrier_table (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .arrive_i        (arrive),
    .bid_i           (tw_ctl_src0_i[BidW-1:0]),
    .wid_i           (tw_ctl_wid_i),
    .size_i          (tw_ctl_src1_i),
    .release_o       (tbl_release),
    .release_wmask_o (tbl_rmask),
    .stall_o         (tbl_stall),
    .dup_o           (tbl_dup),
    .count_o         (tbl_count)
  );

  always_comb begin
    done_d  = 1'b0;
    itag_d  = '0;
    wb_d    = '0;
    spawn_d = 1'b0;
    smask_d = '0;
    pc_d    = '0;
    tmc_d   = 1'b0;
    twid_d  = '0;
    tmask_d = '0;
    stall_d = 1'b0;
    swid_d  = '0;
    rel_d   = 1'b0;
    rmask_d = '0;
    err_d   = err_q;
    spawn_n = (tw_ctl_src0_i > 32'(NUM_WARPS_P)) ? 32'(NUM_WARPS_P) : tw_ctl_src0_i;

    if (accept) begin
      done_d = 1'b1;
      itag_d = tw_ctl_itag_i;
      unique case (tw_ctl_opc_i)
        OpWspawn: begin
          // The issuing warp (warp 0) is already running, so bit 0 is never spawned.
          if (spawn_n > 32'd1) begin
            spawn_d = 1'b1;
            pc_d    = tw_ctl_src1_i;
            for (int i = 1; i < int'(NUM_WARPS_P); i++) smask_d[i] = (32'(i) < spawn_n);
          end
        end
        OpTmc: begin
          tmc_d   = 1'b1;
          twid_d  = tw_ctl_wid_i;
          tmask_d = tw_ctl_src0_i[NUM_THREADS_P-1:0];
        end
        OpBar: begin
          if (bad_bid || tbl_dup) err_d = 1'b1;
          rel_d   = tbl_release;
          rmask_d = tbl_rmask;
          stall_d = tbl_stall;
          swid_d  = tbl_stall ? tw_ctl_wid_i : '0;
        end
        OpBarQry: begin
          if (bad_bid) err_d = 1'b1;
          else         wb_d  = 32'(tbl_count);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      itag_q  <= '0;
      wb_q    <= '0;
      spawn_q <= 1'b0;
      smask_q <= '0;
      pc_q    <= '0;
      tmc_q   <= 1'b0;
      twid_q  <= '0;
      tmask_q <= '0;
      stall_q <= 1'b0;
      swid_q  <= '0;
      rel_q   <= 1'b0;
      rmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      done_q  <= done_d;
      itag_q  <= itag_d;
      wb_q    <= wb_d;
      spawn_q <= spawn_d;
      smask_q <= smask_d;
      pc_q    <= pc_d;
      tmc_q   <= tmc_d;
      twid_q  <= twid_d;
      tmask_q <= tmask_d;
      stall_q <= stall_d;
      swid_q  <= swid_d;
      rel_q   <= rel_d;
      rmask_q <= rmask_d;
      err_q   <= err_d;
    end
  end

  assign tw_ctl_rdy_o           = rdy_q;
  assign tw_ctl_done_o          = done_q;
  assign tw_ctl_itag_o          = itag_q;
  assign tw_ctl_wb_data_o       = wb_q;
  assign tw_ctl_wspawn_vld_o    = spawn_q;
  assign tw_ctl_wspawn_wmask_o  = smask_q;
  assign tw_ctl_wspawn_pc_o     = pc_q;
  assign tw_ctl_tmc_vld_o       = tmc_q;
  assign tw_ctl_tmc_wid_o       = twid_q;
  assign tw_ctl_tmc_tmask_o     = tmask_q;
  assign tw_ctl_stall_vld_o     = stall_q;
  assign tw_ctl_stall_wid_o     = swid_q;
  assign tw_ctl_release_vld_o   = rel_q;
  assign tw_ctl_release_wmask_o = rmask_q;
  assign tw_ctl_err_o           = err_q;

endmodule
